multicycle_control_fsm: RTL

//  Main control FSM for the multicycle MIPS datapath (shared memory port, IR/MDR/A/B/ALUOut regs).

---
 rtl/multicycle_control_fsm_pkg.sv | 58 +++++
 rtl/multicycle_control_fsm_if.sv | 39 +++
 rtl/multicycle_control_fsm_mem_wait_timer.sv | 42 ++++
 rtl/multicycle_control_fsm.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared state encoding, opcode constants and datapath select encodings
// for the multicycle MIPS control FSM.
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EX   = 4'd10,
    ST_ADDI_WB   = 4'd11,
    ST_TRAP      = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control/status bundle between the multicycle control FSM (master) and
// the datapath plus shared memory (slave).
interface multicycle_control_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             ior_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             instr_done;
  logic [CNT_W-1:0] retired_count;
  logic             illegal_op;
  logic             mem_timeout;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, retired_count, illegal_op, mem_timeout
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, retired_count, illegal_op, mem_timeout
  );
endinterface

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Watchdog for memory wait states: counts consecutive cycles without
// mem_ready and flags expiry on the MEM_TIMEOUT-th such cycle (0 disables).
module multicycle_control_fsm_mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned W      = (MEM_TIMEOUT > 32'd1) ? $clog2(MEM_TIMEOUT + 32'd1) : 1;
  localparam logic [W-1:0] LAST  = W'(MEM_TIMEOUT - 32'd1);
  localparam logic         ENABLE = (MEM_TIMEOUT != 32'd0);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Wait-cycle counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Saturating count of waited cycles; LAST is the final permitted value
  always_comb begin
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign expired = ENABLE && count_en && !clear && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath: sequences each
// instruction, drives all datapath controls, traps on faults, counts retires.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_control_fsm_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_count_q, retired_count_d;
  logic             illegal_op_q, illegal_op_d;
  logic             mem_timeout_q, mem_timeout_d;
  ctrl_t            ctl_s;
  ctrl_t            ctl_out_s;
  logic             mem_wait_s;
  logic             wait_cnt_en_s;
  logic             wait_clear_s;
  logic             wait_expired_s;

  // Entry into a wait state always follows a cleared counter, so clearing
  // whenever we are not stalled gives "clear on entry" for free.
  assign mem_wait_s    = (state_q == ST_FETCH) || (state_q == ST_MEM_READ) ||
                         (state_q == ST_MEM_WRITE);
  assign wait_cnt_en_s = mem_wait_s && !bus.mem_ready;
  assign wait_clear_s  = !wait_cnt_en_s;

  multicycle_control_fsm_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (wait_clear_s),
    .count_en(wait_cnt_en_s),
    .expired (wait_expired_s)
  );

  // State, retire counter and sticky fault flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_FETCH;
      retired_count_q <= '0;
      illegal_op_q    <= 1'b0;
      mem_timeout_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      retired_count_q <= retired_count_d;
      illegal_op_q    <= illegal_op_d;
      mem_timeout_q   <= mem_timeout_d;
    end
  end

  // Next state, per-state control decode, fault capture and retire count
  always_comb begin
    state_d         = state_q;
    ctl_s           = '0;
    illegal_op_d    = illegal_op_q;
    mem_timeout_d   = mem_timeout_q;
    retired_count_d = retired_count_q;
    case (state_q)
      ST_FETCH: begin
        ctl_s.mem_read  = 1'b1;
        ctl_s.alu_src_b = SRCB_FOUR;
        ctl_s.ir_write  = bus.mem_ready;
        ctl_s.pc_write  = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = ST_DECODE;
        end else if (wait_expired_s) begin
          state_d       = ST_TRAP;
          mem_timeout_d = ~illegal_op_q;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        ctl_s.alu_src_b = SRCB_IMM_SH2;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_R:         state_d = ST_EXECUTE;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDI_EX;
          default: begin
            state_d      = ST_TRAP;
            illegal_op_d = ~mem_timeout_q;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        ctl_s.alu_src_a = 1'b1;
        ctl_s.alu_src_b = SRCB_IMM;
        if (bus.opcode == OP_LW) begin
          state_d = ST_MEM_READ;
        end else if (bus.opcode == OP_SW) begin
          state_d = ST_MEM_WRITE;
        end else begin
          state_d      = ST_TRAP;
          illegal_op_d = ~mem_timeout_q;
        end
      end
      ST_MEM_READ: begin
        ctl_s.mem_read = 1'b1;
        ctl_s.ior_d    = 1'b1;
        if (bus.mem_ready) begin
          state_d = ST_MEM_WB;
        end else if (wait_expired_s) begin
          state_d       = ST_TRAP;
          mem_timeout_d = ~illegal_op_q;
        end else begin
          state_d = ST_MEM_READ;
        end
      end
      ST_MEM_WB: begin
        ctl_s.mem_to_reg = 1'b1;
        ctl_s.reg_write  = 1'b1;
        ctl_s.instr_done = 1'b1;
        state_d          = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        ctl_s.mem_write  = 1'b1;
        ctl_s.ior_d      = 1'b1;
        ctl_s.instr_done = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = ST_FETCH;
        end else if (wait_expired_s) begin
          state_d       = ST_TRAP;
          mem_timeout_d = ~illegal_op_q;
        end else begin
          state_d = ST_MEM_WRITE;
        end
      end
      ST_EXECUTE: begin
        ctl_s.alu_src_a = 1'b1;
        ctl_s.alu_src_b = SRCB_B;
        ctl_s.alu_op    = ALUOP_FUNCT;
        state_d         = ST_R_WB;
      end
      ST_R_WB: begin
        ctl_s.reg_dst    = 1'b1;
        ctl_s.reg_write  = 1'b1;
        ctl_s.instr_done = 1'b1;
        state_d          = ST_FETCH;
      end
      ST_BRANCH: begin
        ctl_s.alu_src_a     = 1'b1;
        ctl_s.alu_src_b     = SRCB_B;
        ctl_s.alu_op        = ALUOP_SUB;
        ctl_s.pc_write_cond = 1'b1;
        ctl_s.pc_source     = PCSRC_ALUOUT;
        ctl_s.instr_done    = 1'b1;
        state_d             = ST_FETCH;
      end
      ST_JUMP: begin
        ctl_s.pc_write   = 1'b1;
        ctl_s.pc_source  = PCSRC_JUMP;
        ctl_s.instr_done = 1'b1;
        state_d          = ST_FETCH;
      end
      ST_ADDI_EX: begin
        ctl_s.alu_src_a = 1'b1;
        ctl_s.alu_src_b = SRCB_IMM;
        ctl_s.alu_op    = ALUOP_ADD;
        state_d         = ST_ADDI_WB;
      end
      ST_ADDI_WB: begin
        ctl_s.reg_write  = 1'b1;
        ctl_s.instr_done = 1'b1;
        state_d          = ST_FETCH;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_TRAP;
      end
    endcase

    if (ctl_s.instr_done) begin
      retired_count_d = retired_count_q + CNT_W'(1'b1);
    end else begin
      retired_count_d = retired_count_q;
    end
  end

  // Reset parks the state in FETCH, whose decode is non-zero, so gate here.
  assign ctl_out_s = reset ? ctl_s : '0;

  assign bus.pc_write      = ctl_out_s.pc_write;
  assign bus.pc_write_cond = ctl_out_s.pc_write_cond;
  assign bus.ior_d         = ctl_out_s.ior_d;
  assign bus.mem_read      = ctl_out_s.mem_read;
  assign bus.mem_write     = ctl_out_s.mem_write;
  assign bus.ir_write      = ctl_out_s.ir_write;
  assign bus.mem_to_reg    = ctl_out_s.mem_to_reg;
  assign bus.reg_dst       = ctl_out_s.reg_dst;
  assign bus.reg_write     = ctl_out_s.reg_write;
  assign bus.alu_src_a     = ctl_out_s.alu_src_a;
  assign bus.alu_src_b     = ctl_out_s.alu_src_b;
  assign bus.alu_op        = ctl_out_s.alu_op;
  assign bus.pc_source     = ctl_out_s.pc_source;
  assign bus.instr_done    = ctl_out_s.instr_done;
  assign bus.retired_count = retired_count_q;
  assign bus.illegal_op    = illegal_op_q;
  assign bus.mem_timeout   = mem_timeout_q;

endmodule
